// File: rtl/fnd_pkg.sv
// Shared constants and types for the scanned seven-segment time display.
// Segment codes are active-low in the order dp,g,f,e,d,c,b,a.
package fnd_pkg;

    localparam int FND_DIGITS = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        MODE_HM = 1'b0,
        MODE_SM = 1'b1
    } mode_t;

    typedef struct packed {
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        mode_t      mode;
    } time_snap_t;

endpackage

// File: rtl/fnd_time_display_if.sv
// Time bus from the watch/stopwatch datapaths into the FND driver.
interface fnd_time_display_if;

    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       i_mode;

    modport master (output msec, sec, min, hour, i_mode);
    modport slave  (input  msec, sec, min, hour, i_mode);

endinterface

// File: rtl/fnd_time_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern (g..a), with
// dash and blank overrides; dash takes priority over blank.
module bcd_to_7seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        seg = SEG_BLANK[6:0];
        if (dash) begin
            seg = SEG_DASH[6:0];
        end else if (!blank) begin
            unique case (bcd)
                4'd0:    seg = SEG_0[6:0];
                4'd1:    seg = SEG_1[6:0];
                4'd2:    seg = SEG_2[6:0];
                4'd3:    seg = SEG_3[6:0];
                4'd4:    seg = SEG_4[6:0];
                4'd5:    seg = SEG_5[6:0];
                4'd6:    seg = SEG_6[6:0];
                4'd7:    seg = SEG_7[6:0];
                4'd8:    seg = SEG_8[6:0];
                4'd9:    seg = SEG_9[6:0];
                default: seg = SEG_BLANK[6:0];
            endcase
        end
    end

endmodule

// File: rtl/fnd_time_display.sv
// Scanned 4-digit FND driver for the msec/sec/min/hour time bus, snapshotted once per frame.
// Optional macro FND_LEADING_ZERO_BLANK_EN blanks a zero on the leftmost digit.
module fnd_time_display
    import fnd_pkg::*;
#(
    parameter int SYS_CLK_HZ = 100_000_000,
    parameter int SCAN_HZ    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    fnd_time_display_if.slave     tbus,
    output logic [FND_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd_data
);

    localparam int SCAN_DIV = SYS_CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [FND_DIGITS-1:0] COM_ONE  = {{(FND_DIGITS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [1:0]            digit_q, digit_d;
    time_snap_t            snap_q, snap_d;
    logic [FND_DIGITS-1:0] fnd_com_q, fnd_com_d;
    logic [7:0]            fnd_data_q, fnd_data_d;

    logic       scan_tick;
    logic [6:0] hi_val, lo_val;
    logic       hi_bad, lo_bad;
    logic [3:0] hi_tens, hi_ones, lo_tens, lo_ones;
    logic [3:0] digit_bcd;
    logic       digit_dash, digit_blank, dot_lit;
    logic [6:0] digit_seg;

    // Scan timing and the frame-boundary snapshot.
    always_comb begin
        scan_tick  = (scan_cnt_q == CNT_LAST);
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + CNT_ONE;
        digit_d    = scan_tick ? digit_q + 2'd1 : digit_q;
        snap_d     = snap_q;
        if (scan_tick && digit_q == 2'd3) begin
            snap_d.msec = tbus.msec;
            snap_d.sec  = tbus.sec;
            snap_d.min  = tbus.min;
            snap_d.hour = tbus.hour;
            snap_d.mode = mode_t'(tbus.i_mode);
        end
    end

    // Field pair selection and BCD split, always from the snapshot.
    always_comb begin
        if (snap_q.mode == MODE_SM) begin
            hi_val = {1'b0, snap_q.sec};
            lo_val = snap_q.msec;
            hi_bad = (snap_q.sec > 6'd59);
            lo_bad = (snap_q.msec > 7'd99);
        end else begin
            hi_val = {2'b00, snap_q.hour};
            lo_val = {1'b0, snap_q.min};
            hi_bad = (snap_q.hour > 5'd23);
            lo_bad = (snap_q.min > 6'd59);
        end
        hi_tens = 4'(hi_val / 7'd10);
        hi_ones = 4'(hi_val % 7'd10);
        lo_tens = 4'(lo_val / 7'd10);
        lo_ones = 4'(lo_val % 7'd10);
    end

    // Digit mux for the currently scanned position.
    always_comb begin
        digit_bcd   = lo_ones;
        digit_dash  = lo_bad;
        digit_blank = 1'b0;
        unique case (digit_q)
            2'd0: begin
                digit_bcd  = lo_ones;
                digit_dash = lo_bad;
            end
            2'd1: begin
                digit_bcd  = lo_tens;
                digit_dash = lo_bad;
            end
            2'd2: begin
                digit_bcd  = hi_ones;
                digit_dash = hi_bad;
            end
            default: begin
                digit_bcd  = hi_tens;
                digit_dash = hi_bad;
`ifdef FND_LEADING_ZERO_BLANK_EN
                digit_blank = (hi_tens == 4'd0);
`else
                digit_blank = 1'b0;
`endif
            end
        endcase
        dot_lit = (digit_q == 2'd2) &&
                  ((snap_q.mode == MODE_SM) || (snap_q.msec < 7'd50));
    end

    bcd_to_7seg u_seg (
        .bcd   (digit_bcd),
        .dash  (digit_dash),
        .blank (digit_blank),
        .seg   (digit_seg)
    );

    // Output registers load together, one cycle after scan_tick.
    always_comb begin
        fnd_com_d  = fnd_com_q;
        fnd_data_d = fnd_data_q;
        if (scan_tick) begin
            fnd_com_d  = ~(COM_ONE << digit_q);
            fnd_data_d = {~dot_lit, digit_seg};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            snap_q     <= '0;
            fnd_com_q  <= '1;
            fnd_data_q <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            snap_q     <= snap_d;
            fnd_com_q  <= fnd_com_d;
            fnd_data_q <= fnd_data_d;
        end
    end

    assign fnd_com  = fnd_com_q;
    assign fnd_data = fnd_data_q;

endmodule

// File: tb/tb_fnd_time_display.sv
// Directed bench for fnd_time_display with a 4-cycle scan period; honours
// FND_LEADING_ZERO_BLANK_EN when computing the leftmost-digit expectation.
module tb_fnd_time_display;

    logic       clk;
    logic       rst;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int n_tests = 0;
    int n_fail  = 0;

    fnd_time_display_if tbus ();

    fnd_time_display #(
        .SYS_CLK_HZ (40),
        .SCAN_HZ    (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tbus     (tbus.slave),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       mode;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] msec;
        logic [7:0] e3, e2, e1, e0;
    } vec_t;

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] EXP_D3_ZERO = 8'hFF;
`else
    localparam logic [7:0] EXP_D3_ZERO = 8'hC0;
`endif

    function automatic vec_t mk(input string name, input logic mode,
                                input logic [4:0] hour, input logic [5:0] min,
                                input logic [5:0] sec, input logic [6:0] msec,
                                input logic [7:0] e3, input logic [7:0] e2,
                                input logic [7:0] e1, input logic [7:0] e0);
        vec_t v;
        v.name = name; v.mode = mode; v.hour = hour; v.min = min;
        v.sec = sec; v.msec = msec;
        v.e3 = e3; v.e2 = e2; v.e1 = e1; v.e0 = e0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge where fnd_com matches.
    task automatic wait_com(input logic [3:0] want, input string name);
        int n = 0;
        while (fnd_com !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (fnd_com !== want) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: fnd_com=%b, expected %b", name, fnd_com, want);
        end
    endtask

    task automatic wait_new_frame();
        wait_com(4'b1101, "frame_sync_d1");
        wait_com(4'b1110, "frame_sync_d0");
    endtask

    task automatic capture_frame(output logic [7:0] d3, output logic [7:0] d2,
                                 output logic [7:0] d1, output logic [7:0] d0);
        wait_com(4'b1110, "cap_d0"); d0 = fnd_data;
        wait_com(4'b1101, "cap_d1"); d1 = fnd_data;
        wait_com(4'b1011, "cap_d2"); d2 = fnd_data;
        wait_com(4'b0111, "cap_d3"); d3 = fnd_data;
    endtask

    task automatic drive(input logic mode, input logic [4:0] hour, input logic [5:0] min,
                         input logic [5:0] sec, input logic [6:0] msec);
        tbus.i_mode = mode;
        tbus.hour   = hour;
        tbus.min    = min;
        tbus.sec    = sec;
        tbus.msec   = msec;
    endtask

    task automatic check_first_tick(input string tag);
        int n = 0;
        while (fnd_com === 4'b1111 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_com"}, {28'd0, fnd_com}, 32'b1110);
        check({tag, "_data"}, {24'd0, fnd_data}, 32'hC0);
    endtask

    vec_t       vecs[9];
    logic [7:0] d3, d2, d1, d0;

    initial begin
        vecs[0] = mk("hm_13_07_dot",   1'b0, 5'd13, 6'd7,  6'd0,  7'd20,  8'hF9, 8'h30, 8'hC0, 8'hF8);
        vecs[1] = mk("hm_13_07_nodot", 1'b0, 5'd13, 6'd7,  6'd0,  7'd70,  8'hF9, 8'hB0, 8'hC0, 8'hF8);
        vecs[2] = mk("sm_45_09",       1'b1, 5'd13, 6'd7,  6'd45, 7'd9,   8'h99, 8'h12, 8'hC0, 8'h90);
        vecs[3] = mk("sm_45_80_dot",   1'b1, 5'd13, 6'd7,  6'd45, 7'd80,  8'h99, 8'h12, 8'h80, 8'hC0);
        vecs[4] = mk("sm_sec60_dash",  1'b1, 5'd0,  6'd0,  6'd60, 7'd9,   8'hBF, 8'h3F, 8'hC0, 8'h90);
        vecs[5] = mk("sm_msec100",     1'b1, 5'd0,  6'd0,  6'd30, 7'd100, 8'hB0, 8'h40, 8'hBF, 8'hBF);
        vecs[6] = mk("hm_05_42_lz",    1'b0, 5'd5,  6'd42, 6'd0,  7'd0,   EXP_D3_ZERO, 8'h12, 8'h99, 8'hA4);
        vecs[7] = mk("hm_range_both",  1'b0, 5'd24, 6'd60, 6'd0,  7'd60,  8'hBF, 8'hBF, 8'hBF, 8'hBF);
        vecs[8] = mk("hm_23_59_ms49",  1'b0, 5'd23, 6'd59, 6'd0,  7'd49,  8'hA4, 8'h30, 8'h92, 8'h90);

        drive(1'b0, 5'd0, 6'd0, 6'd0, 7'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_com", {28'd0, fnd_com}, 32'b1111);
        check("reset_data", {24'd0, fnd_data}, 32'hFF);
        rst = 1'b1;
        check_first_tick("first_tick");

        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].hour, vecs[i].min, vecs[i].sec, vecs[i].msec);
            wait_new_frame();
            wait_new_frame();
            capture_frame(d3, d2, d1, d0);
            check({vecs[i].name, "_d3"}, {24'd0, d3}, {24'd0, vecs[i].e3});
            check({vecs[i].name, "_d2"}, {24'd0, d2}, {24'd0, vecs[i].e2});
            check({vecs[i].name, "_d1"}, {24'd0, d1}, {24'd0, vecs[i].e1});
            check({vecs[i].name, "_d0"}, {24'd0, d0}, {24'd0, vecs[i].e0});
        end

        // Tearing: 13:59 -> 14:00 changed while digit 1 is on screen.
        drive(1'b0, 5'd13, 6'd59, 6'd0, 7'd20);
        wait_new_frame();
        wait_new_frame();
        wait_com(4'b1101, "tear_d1");
        check("tear_old_d1", {24'd0, fnd_data}, 32'h92);
        drive(1'b0, 5'd14, 6'd0, 6'd0, 7'd20);
        wait_com(4'b1011, "tear_d2");
        check("tear_old_d2", {24'd0, fnd_data}, 32'h30);
        wait_com(4'b0111, "tear_d3");
        check("tear_old_d3", {24'd0, fnd_data}, 32'hF9);
        capture_frame(d3, d2, d1, d0);
        check("tear_new_d3", {24'd0, d3}, 32'hF9);
        check("tear_new_d2", {24'd0, d2}, 32'h19);
        check("tear_new_d1", {24'd0, d1}, 32'hC0);
        check("tear_new_d0", {24'd0, d0}, 32'hC0);

        // Mode switch mid-frame stays on hour.min until the next snapshot.
        wait_com(4'b1101, "mode_d1");
        drive(1'b1, 5'd14, 6'd0, 6'd45, 7'd9);
        wait_com(4'b1011, "mode_d2");
        check("mode_old_d2", {24'd0, fnd_data}, 32'h19);
        wait_com(4'b0111, "mode_d3");
        check("mode_old_d3", {24'd0, fnd_data}, 32'hF9);
        capture_frame(d3, d2, d1, d0);
        check("mode_new_d3", {24'd0, d3}, 32'h99);
        check("mode_new_d2", {24'd0, d2}, 32'h12);
        check("mode_new_d1", {24'd0, d1}, 32'hC0);
        check("mode_new_d0", {24'd0, d0}, 32'h90);

        // Reset mid-frame returns to idle outputs and restarts at digit 0 with zero snapshot.
        wait_com(4'b1011, "midrst_d2");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_com", {28'd0, fnd_com}, 32'b1111);
        check("midrst_data", {24'd0, fnd_data}, 32'hFF);
        rst = 1'b1;
        check_first_tick("midrst_tick");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_time_display.md
# fnd_time_display

Scanned 4-digit seven-segment driver that consumes the `msec`/`sec`/`min`/`hour` time bus produced by the watch and stopwatch datapaths and renders it on the board FND. It sits between the time-keeping datapaths and the top-level FND pins. It time-multiplexes the four digits and snapshots the time bus once per frame so the display never tears. It also splits each field into BCD, selects the displayed field pair by mode, and drives a blinking separator dot.

## Interface
- `SYS_CLK_HZ`, default 100_000_000: system clock frequency.
- `SCAN_HZ`, default 1000: per-digit refresh rate. `SYS_CLK_HZ/SCAN_HZ` must be an integer ≥ 2.
- `clk  in  1`: system clock. The only clock.
- `rst  in  1`: reset. Synchronous, active-low.
- `msec  in  7`: hundredths of a second, legal range 0–99.
- `sec  in  6`: seconds, legal range 0–59.
- `min  in  6`: minutes, legal range 0–59.
- `hour  in  5`: hours, legal range 0–23.
- `i_mode  in  1`: display mode. 0 = `hour.min`, 1 = `sec.msec`.
- `fnd_com  out  4`: active-low digit enables. Bit 0 is the rightmost digit.
- `fnd_data  out  8`: active-low segments, bit order `dp,g,f,e,d,c,b,a`.

## Operation
- **Scan counter:** counts 0 to `SYS_CLK_HZ/SCAN_HZ-1`. It asserts a one-cycle `scan_tick` at the terminal count, then wraps to 0.
- **Digit index:** 2 bits. Advances 0→1→2→3→0 on each `scan_tick`.
- **Frame snapshot:** when `scan_tick` fires with the digit index at 3, the block registers `msec`, `sec`, `min`, `hour` and `i_mode` into snapshot registers. All four digits of one frame always come from a single snapshot.
- **Field selection** (from the snapshot):
  - Mode 0: digits 3,2 = `hour`; digits 1,0 = `min`.
  - Mode 1: digits 3,2 = `sec`; digits 1,0 = `msec`.
- **BCD split:** tens = value/10, ones = value%10.
  - Widths are zero-extended to 7 bits before the split.
  - An out-of-range field (msec>99, sec/min>59, hour>23) shows dash (`0xBF`) on both of its digits.
- **Segment codes, digits 0–9:** `C0 F9 A4 B0 99 92 82 F8 80 90`. Blank is `FF`.
- **Dot:** lit (bit 7 cleared) on digit 2 only.
  - Mode 0: lit while the snapshot `msec` < 50, giving a 1 Hz blink at 50% duty.
  - Mode 1: always lit.
- **Field independence:** the block never alters time values. Inputs are treated as free-running.

## Timing
- Reset values: scan counter 0, digit index 0, snapshots 0, `i_mode` snapshot 0, `fnd_com`=`4'b1111`, `fnd_data`=`8'hFF`.
- The first digit is driven one cycle after the first `scan_tick` following reset release. It shows the zero snapshot, i.e. "00.00" with the dot rule applied.
- `fnd_com` and `fnd_data` are registered. Both change together, exactly one cycle after `scan_tick`.
- Exactly one `fnd_com` bit is low at any time after the first tick.
- **Snapshot latency:** an input change is displayed starting at the next frame boundary. Worst case is 4 scan periods plus 1 cycle.
- **Mode change mid-frame:** ignored until the snapshot. The frame never mixes modes.
- **Reset mid-frame:** on the next clock edge all state returns to the reset values above. The scan restarts at digit 0.

## Configuration
- `FND_LEADING_ZERO_BLANK_EN`
  - **Defined:** when digit 3's BCD value is 0 it shows blank (`FF`). Dash and the dot rule are unaffected; digit 3 never carries a dot.
  - **Undefined:** digit 3 shows `C0` for zero.

## Structure
- Package `fnd_pkg`:
  - Segment constants: `SEG_0`…`SEG_9`, `SEG_DASH`, `SEG_BLANK`.
  - `FND_DIGITS = 4`.
  - Mode encodings `MODE_HM = 1'b0`, `MODE_SM = 1'b1`.
- Sub-module `bcd_to_7seg`: combinational 4-bit BCD to active-low 7-segment, plus dash/blank select inputs. Instantiated once on the muxed digit.
- The top holds the scan counter, digit index, snapshot registers, BCD split, field mux and output registers.

## Test plan
All scenarios use `SYS_CLK_HZ=40`, `SCAN_HZ=10` (tick every 4 cycles).
- **Reset:** hold `rst`=0 for 3 cycles, then release. Outputs stay `1111`/`FF` until the first tick. Then digit 0 gets `fnd_com`=`1110`, `fnd_data`=`C0`.
- **Mode 0:** hour=13, min=7, msec=20, wait 2 frames. Per digit: d3 `F9` (1), d2 `30` (3 with dot), d1 `C0` (0), d0 `F8` (7). Set msec=70: d2 becomes `B0` at the next frame.
- **Mode 1:** sec=45, msec=9. Per digit: d3 `99`, d2 `12`, d1 `C0`, d0 `90`. The dot stays lit regardless of msec.
- **Tearing:** change min 59→0 and hour 13→14 while digit 1 is active. The current frame still shows 13/59 on all digits. The next frame shows 14/00.
- **Range:** sec=60 in mode 1 gives d3 and d2 as `BF` and `3F` (dash, plus dot on d2). msec=100 gives d1 and d0 as `BF`.
- **Macro:** with `FND_LEADING_ZERO_BLANK_EN`, hour=5 in mode 0 makes d3 `FF`. Without it, d3 is `C0`.
